// File: rtl/da_pkg.sv
// Shared constants, state encoding and address helpers for the DA table builder
// and the downstream `da` core.
package da_pkg;
  localparam int NUM_ROM   = 8;
  localparam int ROM_DEPTH = 256;
  localparam int NUM_TAP   = 64;
  localparam int COEF_W    = 16;
  localparam int CIN_W     = 20;
  localparam int ADDR_W    = 11;

  typedef enum logic {IDLE, GEN} state_e;

  // The top three address bits pick which of the 8 ROMs a table word belongs to.
  function automatic logic [2:0] rom_index(input logic [ADDR_W-1:0] addr);
    return addr[10:8];
  endfunction
endpackage

// File: rtl/da_psum_tree.sv
// Combinational partial-sum tree: adds the taps whose select bit is set.
// Each term is sign-extended to CIN_W first, so CIN_W >= COEF_W+3 cannot overflow.
module da_psum_tree #(
  parameter int COEF_W   = 16,
  parameter int CIN_W    = 20,
  parameter int NUM_TERM = 8
) (
  input  logic [NUM_TERM-1:0][COEF_W-1:0] taps_i,
  input  logic [NUM_TERM-1:0]             sel_i,
  output logic [CIN_W-1:0]                psum_o
);
  logic [NUM_TERM-1:0][CIN_W-1:0] term;

  for (genvar b = 0; b < NUM_TERM; b++) begin : g_term
    assign term[b] = sel_i[b] ? {{(CIN_W-COEF_W){taps_i[b][COEF_W-1]}}, taps_i[b]}
                              : '0;
  end

  always_comb begin
    psum_o = '0;
    for (int b = 0; b < NUM_TERM; b++) psum_o = psum_o + term[b];
  end
endmodule

// File: rtl/da_rom_builder.sv
// Collects 64 taps, then streams all 8x256 DA partial-sum words to the `da` load port.
// Outputs are registered: word n appears on CADDR/CIN one cycle after n is issued.
module da_rom_builder #(
  parameter int COEF_W = 16,
  parameter int CIN_W  = 20,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [ADDR_W-1:0] CADDR,
  output logic [CIN_W-1:0]  CIN,
  output logic              CLOAD,
  output logic              valid_in,
  output logic              busy,
  output logic              done
);
  import da_pkg::state_e;
  import da_pkg::IDLE;
  import da_pkg::GEN;
  import da_pkg::NUM_TAP;
  import da_pkg::rom_index;

  state_e state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   n_q, n_d;        // extra MSB marks "all words issued"
  logic [NUM_TAP-1:0][COEF_W-1:0] tap_q;

  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [CIN_W-1:0]  cin_q, cin_d;
  logic              cload_q, cload_d, done_q, done_d;

  logic              hs, issue, last_out;
  logic [2:0]        rom;
  logic [7:0][COEF_W-1:0] sel_taps;
  logic [CIN_W-1:0]  psum;

  assign hs       = (state_q == IDLE) && coef_valid && !clear;
  assign issue    = (state_q == GEN) && !n_q[ADDR_W] && !clear;
  assign last_out = cload_q && (caddr_q == '1);
  assign rom      = rom_index(n_q[ADDR_W-1:0]);

  for (genvar b = 0; b < 8; b++) begin : g_sel
    assign sel_taps[b] = tap_q[{rom, 3'(b)}];
  end

  da_psum_tree #(.COEF_W(COEF_W), .CIN_W(CIN_W), .NUM_TERM(8)) u_tree (
    .taps_i (sel_taps),
    .sel_i  (n_q[7:0]),
    .psum_o (psum)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: leave GEN once the final word has been presented on the port
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs && cnt_q == 6'(NUM_TAP-1)) state_d = GEN;
      GEN:  if (clear || last_out)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    coef_ready = (state_q == IDLE);
    busy       = (state_q == GEN);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (hs) cnt_d = cnt_q + 6'd1;
    n_d = n_q;
    if (state_q != GEN) n_d = '0;
    else if (issue)     n_d = n_q + 1'b1;
    cload_d = issue;
    caddr_d = issue ? n_q[ADDR_W-1:0] : '0;
    cin_d   = issue ? psum : '0;
    done_d  = (state_q == GEN) && last_out && !clear;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      n_q     <= '0;
      caddr_q <= '0;
      cin_q   <= '0;
      cload_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      cload_q <= cload_d;
      done_q  <= done_d;
    end
  end

  // Tap storage is deliberately left unreset; a full reload always precedes use.
  always_ff @(posedge clk) begin
    if (hs) tap_q[cnt_q] <= coef_in;
  end

  assign CADDR    = caddr_q;
  assign CIN      = cin_q;
  assign CLOAD    = cload_q;
  assign valid_in = cload_q;
  assign done     = done_q;
endmodule

// File: tb/tb_da_rom_builder.sv
// Directed bench for da_rom_builder: hand-computed table words plus a tap-sum
// model over every captured word, handshake, clear and async-reset behaviour.
module tb_da_rom_builder;
  logic        clk = 1'b0;
  logic        resetn, clear, coef_valid;
  logic [15:0] coef_in;
  logic        coef_ready, CLOAD, valid_in, busy, done;
  logic [10:0] CADDR;
  logic [19:0] CIN;

  int          n_chk = 0, n_fail = 0;
  int          tb_taps [64];
  logic [19:0] cin_cap [2048];

  da_rom_builder dut (
    .clk(clk), .resetn(resetn), .clear(clear), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .CADDR(CADDR), .CIN(CIN),
    .CLOAD(CLOAD), .valid_in(valid_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [10:0] a);
    int s = 0;
    for (int b = 0; b < 8; b++)
      if (a[b]) s += tb_taps[int'(a[10:8]) * 8 + b];
    return s[19:0];
  endfunction

  task automatic load_range(input int lo, input int hi, input bit toggle);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      coef_valid = 1'b1;
      coef_in    = tb_taps[i][15:0];
      if (toggle && i < hi) begin
        @(negedge clk);
        coef_valid = 1'b0;
      end
    end
    @(negedge clk);
    coef_valid = 1'b0;
  endtask

  // Captures one GEN burst; checks order, model, contiguity and the done pulse.
  task automatic capture(input bit poke, output int first_wait);
    int nw = 0, order_err = 0, model_err = 0, hs_err = 0;
    first_wait = 0;
    @(negedge clk);
    while (!CLOAD && first_wait < 200) begin
      @(negedge clk);
      first_wait++;
    end
    chk("gen_start", 32'(CLOAD), 32'd1);
    while (CLOAD && nw < 2100) begin
      if (CADDR != nw[10:0]) order_err++;
      cin_cap[CADDR] = CIN;
      if (CIN != model(CADDR)) model_err++;
      if (coef_ready || !busy || !valid_in) hs_err++;
      if (poke) begin
        coef_valid = nw[0];
        coef_in    = 16'h1234;
      end
      nw++;
      @(negedge clk);
    end
    coef_valid = 1'b0;
    chk("nwords", nw, 2048);
    chk("order_err", order_err, 0);
    chk("model_err", model_err, 0);
    chk("gen_hs_err", hs_err, 0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_caddr", 32'(CADDR), 32'd0);
    chk("end_cin", 32'(CIN), 32'd0);
    chk("end_ready", 32'(coef_ready), 32'd1);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 32'd0);
  endtask

  initial begin
    int fw, err;
    resetn = 1'b0; clear = 1'b0; coef_valid = 1'b0; coef_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_cload", 32'(CLOAD), 32'd0);
    chk("rst_caddr", 32'(CADDR), 32'd0);
    chk("rst_cin", 32'(CIN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(coef_ready), 32'd1);

    // All taps 1: CIN is popcount of the entry bits
    foreach (tb_taps[i]) tb_taps[i] = 1;
    load_range(0, 63, 1'b0);
    capture(1'b0, fw);
    chk("ones_0ff", 32'(cin_cap[11'h0FF]), 32'd8);
    chk("ones_000", 32'(cin_cap[11'h000]), 32'd0);
    chk("ones_7aa", 32'(cin_cap[11'h7AA]), 32'd4);

    // Single negative tap, toggling valid, coef pokes during GEN
    foreach (tb_taps[i]) tb_taps[i] = 0;
    tb_taps[9] = -5;
    load_range(0, 63, 1'b1);
    chk("tog_busy", 32'(busy), 32'd1);
    chk("tog_cload", 32'(CLOAD), 32'd0);
    chk("tog_ready", 32'(coef_ready), 32'd0);
    capture(1'b1, fw);
    chk("tog_lat", fw, 0);
    chk("neg_102", 32'(cin_cap[11'h102]), 32'hFFFFB);
    chk("neg_101", 32'(cin_cap[11'h101]), 32'd0);
    chk("neg_0ff", 32'(cin_cap[11'h0FF]), 32'd0);
    chk("neg_2ff", 32'(cin_cap[11'h2FF]), 32'd0);

    // Extremes
    foreach (tb_taps[i]) tb_taps[i] = 32767;
    load_range(0, 63, 1'b0);
    capture(1'b0, fw);
    chk("max_7ff", 32'(cin_cap[11'h7FF]), 32'd262136);
    foreach (tb_taps[i]) tb_taps[i] = -32768;
    load_range(0, 63, 1'b0);
    capture(1'b0, fw);
    chk("min_7ff", 32'(cin_cap[11'h7FF]), 32'hC0000);

    // Clear mid-GEN at CADDR 0x300
    foreach (tb_taps[i]) tb_taps[i] = i - 32;
    load_range(0, 63, 1'b0);
    fw = 0;
    while (!(CLOAD && CADDR == 11'h300) && fw < 3000) begin
      @(negedge clk);
      fw++;
    end
    chk("clr_reach", 32'(CADDR), 32'h300);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_cload", 32'(CLOAD), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_ready", 32'(coef_ready), 32'd1);
    @(negedge clk);
    chk("clr_done2", 32'(done), 32'd0);

    // Clear in IDLE drops partial taps; simultaneous handshake is dropped too
    load_range(0, 9, 1'b0);
    clear = 1'b1; coef_valid = 1'b1; coef_in = 16'h7777;
    @(negedge clk);
    clear = 1'b0; coef_valid = 1'b0;
    load_range(0, 63, 1'b0);
    capture(1'b0, fw);
    chk("clr_301", 32'(cin_cap[11'h301]), 32'hFFFF8);

    // Async reset between edges mid-GEN
    load_range(0, 63, 1'b0);
    repeat (6) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_cload", 32'(CLOAD), 32'd0);
    chk("arst_caddr", 32'(CADDR), 32'd0);
    chk("arst_cin", 32'(CIN), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    foreach (tb_taps[i]) tb_taps[i] = 2;
    load_range(0, 62, 1'b0);
    err = 0;
    repeat (8) begin
      @(negedge clk);
      if (CLOAD || busy) err++;
    end
    chk("arst_63_idle", err, 0);
    load_range(63, 63, 1'b0);
    capture(1'b0, fw);
    chk("arst_0ff", 32'(cin_cap[11'h0FF]), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/da_rom_builder.md
Name: da_rom_builder

Overview:
- Builds the distributed-arithmetic partial-sum tables for the `da` FIR core from raw filter taps.
- Accepts 64 signed taps over a valid/ready stream, in order h0..h63.
- Then emits all 2048 table words (8 ROMs x 256) on the `da` coefficient-load port: one word per cycle, contiguous, no stalls.
- Sits directly upstream of `da` and replaces bench-driven table loading.

Parameters:
- COEF_W, 16, signed tap width.
- CIN_W, 20, table word width; must satisfy CIN_W >= COEF_W+3.
- ADDR_W, 11, table address width: 3-bit ROM index plus 8-bit entry.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns to IDLE and discards partially collected taps.
- coef_in  in  COEF_W  signed tap value.
- coef_valid  in  1  tap valid.
- coef_ready  out  1  high only in IDLE.
- CADDR  out  ADDR_W  table address; connects to da.CADDR.
- CIN  out  CIN_W  signed table word; connects to da.CIN.
- CLOAD  out  1  table write strobe; connects to da.CLOAD.
- valid_in  out  1  equal to CLOAD; connects to da.valid_in.
- busy  out  1  high in GEN.
- done  out  1  one-cycle pulse after the last table word.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; tap count 0; CADDR=0; CIN=0; CLOAD=0; valid_in=0; busy=0; done=0; coef_ready=1 once reset deasserts. The tap register file is not reset.
- IDLE:
  - coef_ready=1.
  - Each cycle with coef_valid=1 writes coef_in to tap[cnt] and increments cnt. Only handshakes count; gaps in coef_valid are ignored.
  - The handshake that writes tap[63] moves the block to GEN the next cycle, with the address counter at 0.
- GEN:
  - coef_ready=0; busy=1. The address counter n runs 0..2047, +1 per cycle.
  - Outputs are registered, 1-cycle latency: the cycle after n is presented, CADDR=n, CLOAD=valid_in=1, and CIN = sign_extend( sum over b=0..7 of (n[b] ? tap[8*n[10:8]+b] : 0) ).
  - CLOAD is high for exactly 2048 consecutive cycles.
- End of GEN:
  - The cycle after the CADDR=2047 word: CLOAD=0, CADDR=0, CIN=0, done=1 for one cycle, busy=0.
  - The state returns to IDLE with cnt=0. A new tap set may then be loaded, overwriting the old one.
- Arithmetic:
  - Adder tree over 8 terms, each sign-extended to CIN_W before summing; no saturation is needed at defaults.
  - The tree may be a single combinational stage. If the tree is pipelined, CADDR/CLOAD must be delayed to stay aligned and the latency documented in the header; the 2048-cycle contiguity requirement is unchanged.
- Idle outputs: when CLOAD=0, CADDR and CIN are held at 0.
- clear:
  - In IDLE: cnt←0.
  - In GEN: CLOAD drops the next cycle, no done pulse, state IDLE, cnt=0.
  - clear has priority over a simultaneous coef handshake; that tap is dropped.
- Reset mid-GEN: outputs go to reset values immediately. The downstream table is partially written and must be reloaded.
- coef_valid in GEN is ignored; no tap is accepted.

Decomposition:
- Shared package da_pkg holds:
  - constants NUM_ROM=8, ROM_DEPTH=256, NUM_TAP=64, COEF_W, CIN_W, ADDR_W;
  - state enum {IDLE, GEN};
  - a function rom_index(addr) returning addr[10:8].
- One natural sub-module: da_psum_tree. It is combinational, takes 8 taps, an 8-bit select and CIN_W output, and is reusable by the `da` verification model.

Test Plan:
- All taps=1 -> CIN=popcount(CADDR[7:0]) for every word. CADDR 0x0FF gives CIN 8; 0x000 gives 0; 0x7AA gives 4. Exactly 2048 CLOAD cycles, then done=1 for one cycle.
- tap[9]=-5, all others 0 -> CADDR 0x102 gives CIN 0xFFFFB (-5); 0x101 gives 0; 0x0FF gives 0; 0x2FF gives 0.
- All taps=32767 -> CADDR 0x7FF gives CIN 262136. All taps=-32768 -> CADDR 0x7FF gives CIN -262144 (0xC0000).
- Load 64 taps with coef_valid toggling 1,0,1,0 -> GEN starts 1 cycle after the 64th handshake. coef_ready=0 throughout GEN; coef_valid pulses during GEN change nothing.
- Assert clear at CADDR 0x300 in GEN -> CLOAD=0 the next cycle, no done pulse, coef_ready=1. Reload, then a full 2048-word sequence from CADDR 0.
- Drop resetn asynchronously mid-GEN, between clock edges -> CLOAD, CADDR and CIN are 0 before the next edge. After release, 64 new taps are required before any CLOAD.
